// File: rtl/sandwich_tester.sv
// Walks the 3-bit {b,h,s} pattern space, holding each pattern HOLD_CYCLES cycles, and compares v to expected.
// Define SANDWICH_TESTER_LOOP_EN to restart automatically after each DONE cycle instead of waiting for start.
module sandwich_tester #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       v,
  output logic       b,
  output logic       h,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] ERR_MAX   = 4'd8;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] err_q, err_d;
  logic [7:0] fail_q, fail_d;
  logic [2:0] pat_q, pat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fail_d  = fail_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          hold_d  = 4'd0;
          err_d   = 4'd0;
          fail_d  = 8'd0;
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) state_d = SAMPLE;
        else                     hold_d  = hold_q + 4'd1;
      end
      SAMPLE: begin
        if (v != expected[idx_q]) begin
          fail_d[idx_q] = 1'b1;
          if (err_q < ERR_MAX) err_d = err_q + 4'd1;
        end
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 3'd1;
          hold_d  = 4'd0;
        end
      end
      DONE: begin
`ifdef SANDWICH_TESTER_LOOP_EN
        state_d = DRIVE;
        idx_d   = 3'd0;
        hold_d  = 4'd0;
        err_d   = 4'd0;
        fail_d  = 8'd0;
`else
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          hold_d  = 4'd0;
          err_d   = 4'd0;
          fail_d  = 8'd0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    pat_d  = busy_d ? idx_d : 3'd0;
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == 4'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      hold_q  <= 4'd0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
      pat_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {b, h, s}  = pat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_q;

endmodule

// File: tb/tb_sandwich_tester.sv
// Directed bench for sandwich_tester with HOLD_CYCLES=4 (one pattern every 5 cycles, 40-cycle run).
module tb_sandwich_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] expected;
  logic [7:0] v_map;
  logic       v;
  logic       b, h, s, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Bench-side model of the device under test: its response to each pattern.
  assign v = v_map[{b, h, s}];

  sandwich_tester #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .v(v),
    .b(b), .h(h), .s(s), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses start across one rising edge; returns at the negedge just after it.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pat"},  {29'd0, b, h, s}, 32'd0);
    check({tag, "_busy"}, busy,      1'b0);
    check({tag, "_done"}, done,      1'b0);
    check({tag, "_pass"}, pass,      1'b0);
    check({tag, "_err"},  err_count, 4'd0);
    check({tag, "_fail"}, fail_vec,  8'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    expected = 8'hA5;
    v_map    = 8'hA5;
    cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cycles(2);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);

`ifndef SANDWICH_TESTER_LOOP_EN
    // Clean run: each pattern held 5 cycles, done exactly 40 edges after start.
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      check("run_pat",  {29'd0, b, h, s}, 32'(i / 5));
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      @(negedge clk);
    end
    check("clean_done", done,      1'b1);
    check("clean_busy", busy,      1'b0);
    check("clean_pass", pass,      1'b1);
    check("clean_err",  err_count, 4'd0);
    check("clean_fail", fail_vec,  8'h00);
    check("clean_pat",  {29'd0, b, h, s}, 32'd0);
    cycles(3);
    check("done_held", done, 1'b1);

    // Mismatches at patterns 2 and 6; restart from DONE clears the previous results.
    expected = 8'h00;
    v_map    = 8'h44;
    pulse_start();
    check("restart_busy", busy,      1'b1);
    check("restart_err",  err_count, 4'd0);
    cycles(40);
    check("two_done", done,      1'b1);
    check("two_err",  err_count, 4'd2);
    check("two_fail", fail_vec,  8'h44);
    check("two_pass", pass,      1'b0);

    // v stuck at 1: every pattern fails, count tops out at 8.
    v_map = 8'hFF;
    pulse_start();
    cycles(40);
    check("stuck_err",  err_count, 4'd8);
    check("stuck_fail", fail_vec,  8'hFF);
    check("stuck_pass", pass,      1'b0);
    check("stuck_done", done,      1'b1);

    // Asynchronous reset during pattern 3.
    expected = 8'hA5;
    v_map    = 8'h00;
    pulse_start();
    cycles(16);
    check("pre_rst_pat",  {29'd0, b, h, s}, 32'd3);
    check("pre_rst_err",  err_count, 4'd2);
    check("pre_rst_fail", fail_vec,  8'h05);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_busy", busy, 1'b0);
    v_map = 8'hA5;
    pulse_start();
    check("rerun_pat0", {29'd0, b, h, s}, 32'd0);
    cycles(39);
    check("rerun_not_done", done, 1'b0);
    check("rerun_pat7", {29'd0, b, h, s}, 32'd7);
    @(negedge clk);
    check("rerun_done", done, 1'b1);
    check("rerun_pass", pass, 1'b1);

    // start held from mid-run: ignored while busy, relaunches from DONE.
    expected = 8'h00;
    v_map    = 8'h44;
    pulse_start();
    cycles(10);
    start = 1'b1;
    cycles(10);
    check("held_no_restart", {29'd0, b, h, s}, 32'd4);
    cycles(20);
    check("held_done", done,      1'b1);
    check("held_err",  err_count, 4'd2);
    @(negedge clk);
    start = 1'b0;
    check("held_relaunch_busy", busy,      1'b1);
    check("held_relaunch_pat",  {29'd0, b, h, s}, 32'd0);
    check("held_relaunch_err",  err_count, 4'd0);
    check("held_relaunch_fail", fail_vec,  8'h00);
`else
    // Loop mode: done pulses one cycle every 41 cycles, pattern 000 follows.
    v_map = 8'h00;
    pulse_start();
    cycles(40);
    check("loop_done1", done,      1'b1);
    check("loop_err1",  err_count, 4'd4);
    @(negedge clk);
    check("loop_done_drop", done, 1'b0);
    check("loop_busy",      busy, 1'b1);
    check("loop_pat0",      {29'd0, b, h, s}, 32'd0);
    check("loop_err_clr",   err_count, 4'd0);
    cycles(39);
    check("loop_not_yet", done, 1'b0);
    @(negedge clk);
    check("loop_done2", done, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
